// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage.
//
// Takes one op from execute, runs the level handshake with the memory
// controller (mm_e up, wait mm_ok up, mm_e down, wait mm_ok down), then
// retires exactly one write-back pulse per op. Pass-through (NONE) ops
// retire in the accepting cycle without touching memory.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ex_valid/op/addr/data/rd operation from execute (held while mem_busy)
//   mem_busy                 stall to execute (state != IDLE)
//   mm_e/a/n_i/wr/cu         request to memory controller
//   mm_ok, mm_n_o            completion level and load data
//   wb_valid/rd/data         retire pulse to write-back
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_data,
    input  logic [4:0]  ex_rd,
    output logic        mem_busy,
    output logic        mm_e,
    output logic [31:0] mm_a,
    output logic [31:0] mm_n_i,
    output logic        mm_wr,
    output logic [1:0]  mm_cu,
    input  logic        mm_ok,
    input  logic [31:0] mm_n_o,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RELEASE = 2'd2} state_t;

    state_t      state, state_nx;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] ld_q;
    logic        is_mem;
    logic [1:0]  cu_dec;
    logic [31:0] ld_ext;

    // Width decode; unknown codes fall through to pass-through.
    always_comb begin
        is_mem = 1'b1;
        cu_dec = 2'd0;
        case (ex_op)
            4'd1, 4'd4, 4'd9:  cu_dec = 2'd0;
            4'd2, 4'd5, 4'd10: cu_dec = 2'd1;
            4'd3, 4'd11:       cu_dec = 2'd3;
            default:           is_mem = 1'b0;
        endcase
    end

    // Load data is captured low-aligned; only extension is needed here.
    always_comb begin
        ld_ext = ld_q;
        case (op_q)
            4'd1:    ld_ext = {{24{ld_q[7]}}, ld_q[7:0]};
            4'd4:    ld_ext = {24'd0, ld_q[7:0]};
            4'd2:    ld_ext = {{16{ld_q[15]}}, ld_q[15:0]};
            4'd5:    ld_ext = {16'd0, ld_q[15:0]};
            default: ld_ext = ld_q;
        endcase
    end

    assign mem_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ex_valid && is_mem) state_nx = ACCESS;
            ACCESS:  if (mm_ok)              state_nx = RELEASE;
            // Controller re-arms only once it sees mm_e low, so retire waits
            // for mm_ok to fall; a new request can never meet a stale mm_ok.
            RELEASE: if (!mm_ok)             state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 4'd0;
            rd_q     <= 5'd0;
            ld_q     <= 32'd0;
            mm_e     <= 1'b0;
            mm_a     <= 32'd0;
            mm_n_i   <= 32'd0;
            mm_wr    <= 1'b0;
            mm_cu    <= 2'd0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (is_mem) begin
                            op_q   <= ex_op;
                            rd_q   <= ex_rd;
                            mm_a   <= ex_addr;
                            mm_n_i <= ex_data;
                            mm_wr  <= ex_op[3];
                            mm_cu  <= cu_dec;
                            mm_e   <= 1'b1;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_data;
                        end
                    end
                end
                ACCESS: begin
                    if (mm_ok) begin
                        ld_q <= mm_n_o;
                        mm_e <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!mm_ok) begin
                        wb_valid <= 1'b1;
                        if (op_q[3]) begin
                            wb_rd   <= 5'd0;
                            wb_data <= 32'd0;
                        end else begin
                            wb_rd   <= rd_q;
                            wb_data <= ld_ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
